// File: rtl/leaf_uplink_port.sv
// Leaf-side spine link endpoint: TX buffers one local packet and bursts it with a routing
// header and trailing idle gap; RX decodes spine bursts, delivers own traffic, counts drops.
module leaf_uplink_port #(
  parameter logic [3:0]  GROUP_ID   = 4'b0110,
  parameter logic [1:0]  LEAF_ID    = 2'd0,
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MAX_LEN    = 8,
  parameter int unsigned TX_GAP     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] loc_data,
  input  logic [5:0]        loc_dest,
  input  logic              loc_valid,
  input  logic              loc_last,
  output logic              loc_ready,
  output logic [DWIDTH-1:0] up_data,
  output logic              up_valid,
  input  logic [DWIDTH-1:0] dn_data,
  input  logic              dn_valid,
  output logic [DWIDTH-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_last,
  output logic [7:0]        rx_drop_cnt,
  output logic              tx_busy
);

  localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0]  MaxLen  = 4'(MAX_LEN);
  localparam logic [7:0]  GapLast = 8'(TX_GAP - 1);
  localparam logic [5:0]  OwnAddr = {GROUP_ID, LEAF_ID};

  typedef enum logic [1:0] {StFill, StHdr, StPay, StGap} tx_state_e;
  typedef enum logic {StRHdr, StRPay} rx_state_e;

  tx_state_e         tx_state_q, tx_state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        rd_q, rd_d;
  logic [7:0]        gap_q, gap_d;
  logic [5:0]        dest_q, dest_d;
  logic [DWIDTH-1:0] up_data_q, up_data_d;
  logic              up_valid_q, up_valid_d;
  logic [DWIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_idx, rd_idx;
  logic              accept;

  rx_state_e         rx_state_q, rx_state_d;
  logic [3:0]        rem_q, rem_d;
  logic              del_q, del_d;
  logic [DWIDTH-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_last_q, rx_last_d;
  logic [7:0]        drop_q, drop_d;
  logic              drop_inc;

  // Gated by reset so the local side sees not-ready throughout reset.
  assign loc_ready = reset && (tx_state_q == StFill);
  assign accept    = loc_valid && loc_ready;
  assign wr_idx    = AW'(cnt_q);
  assign rd_idx    = AW'(rd_q);

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_idx] <= loc_data;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    gap_d      = gap_q;
    dest_d     = dest_q;
    up_valid_d = 1'b0;
    up_data_d  = '0;
    unique case (tx_state_q)
      StFill: begin
        if (accept) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd0) dest_d = loc_dest;
          // MAX_LEN-th word closes the packet even without loc_last (truncation).
          if (loc_last || (cnt_q + 4'd1 == MaxLen)) tx_state_d = StHdr;
        end
      end
      StHdr: begin
        up_valid_d = 1'b1;
        up_data_d  = {dest_q, GROUP_ID, LEAF_ID, cnt_q};
        rd_d       = 4'd0;
        tx_state_d = StPay;
      end
      StPay: begin
        up_valid_d = 1'b1;
        up_data_d  = mem_q[rd_idx];
        rd_d       = rd_q + 4'd1;
        if (rd_q == cnt_q - 4'd1) begin
          cnt_d      = 4'd0;
          gap_d      = 8'd0;
          tx_state_d = (TX_GAP == 0) ? StFill : StGap;
        end
      end
      StGap: begin
        if (gap_q == GapLast) tx_state_d = StFill;
        else                  gap_d      = gap_q + 8'd1;
      end
      default: tx_state_d = StFill;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rem_d      = rem_q;
    del_d      = del_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_last_d  = 1'b0;
    drop_inc   = 1'b0;
    unique case (rx_state_q)
      StRHdr: begin
        if (dn_valid) begin
          if (dn_data[3:0] == 4'd0) begin
            drop_inc = 1'b1;
          end else begin
            rem_d      = dn_data[3:0];
            del_d      = (dn_data[15:10] == OwnAddr);
            rx_state_d = StRPay;
          end
        end
      end
      StRPay: begin
        if (dn_valid) begin
          rem_d = rem_q - 4'd1;
          if (del_q) begin
            rx_valid_d = 1'b1;
            rx_data_d  = dn_data;
            rx_last_d  = (rem_q == 4'd1);
          end else if (rem_q == 4'd1) begin
            drop_inc = 1'b1;
          end
          if (rem_q == 4'd1) rx_state_d = StRHdr;
        end
      end
      default: rx_state_d = StRHdr;
    endcase
    drop_d = (drop_inc && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= StFill;
      cnt_q      <= '0;
      rd_q       <= '0;
      gap_q      <= '0;
      dest_q     <= '0;
      up_data_q  <= '0;
      up_valid_q <= 1'b0;
      rx_state_q <= StRHdr;
      rem_q      <= '0;
      del_q      <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_last_q  <= 1'b0;
      drop_q     <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      gap_q      <= gap_d;
      dest_q     <= dest_d;
      up_data_q  <= up_data_d;
      up_valid_q <= up_valid_d;
      rx_state_q <= rx_state_d;
      rem_q      <= rem_d;
      del_q      <= del_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_last_q  <= rx_last_d;
      drop_q     <= drop_d;
    end
  end

  assign up_data     = up_data_q;
  assign up_valid    = up_valid_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_last     = rx_last_q;
  assign rx_drop_cnt = drop_q;
  assign tx_busy     = (tx_state_q != StFill);

endmodule
